vault_mining_scheduler: RTL and testbench
=========================================

# vault_mining_scheduler

Parametrised nonce-range scheduler and result collector for the vault mining layer. It accepts one work package at a time and sweeps the full nonce space across `LANES` external hash lanes, issuing `LANES` consecutive nonces per cycle. It gathers golden-nonce hits into a show-ahead FIFO with a valid/ready drain and measures the real issued-hash rate over a fixed cycle window. It sits between the work feeder and the hash-lane array, and replaces the fixed single-core tracker with its constant hashrate.

## Interface
- `LANES`, 4: hash lanes; power of two, 1–16.
- `NONCE_W`, 32: nonce width; must be at least log2(`LANES`) + 1.
- `HDR_W`, 640: work package (block header) width.
- `LANE_LAT`, 64: cycles from a lane issue to the latest possible hit for that issue; at least 1.
- `FIFO_DEPTH`, 4: golden-nonce FIFO entries; power of two.
- `WINDOW`, 100000000: hashrate sample window in cycles; at least 2.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `work_valid` in 1: work package offered.
- `work_header` in `HDR_W`: work package.
- `work_ready` out 1: the block is idle and can accept work.
- `work_abort` in 1: abandon the current job.
- `lane_header` out `HDR_W`: latched header, held stable for the whole job.
- `lane_issue` out 1: all lanes evaluate their `lane_nonce` slice this cycle.
- `lane_nonce` out `LANES*NONCE_W`: slice i carries base + i.
- `lane_hit` in `LANES`: per-lane hit strobe.
- `lane_hit_nonce` in `LANES*NONCE_W`: per-lane hit nonce.
- `gold_valid` out 1: FIFO is non-empty.
- `gold_nonce` out `NONCE_W`: FIFO head.
- `gold_ready` in 1: consumer pops the head.
- `hashrate` out 32: nonces issued during the last completed window.
- `drop_count` out 16: number of dropped hits; saturating.
- `busy` out 1: state is not IDLE.
- `job_done` out 1: one-cycle pulse when a sweep completes naturally.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - `work_ready`=1.
  - When `work_valid` is high, latch the header, clear base, go to RUN.
- RUN:
  - `lane_issue`=1 every cycle; base += `LANES` (modulo 2^`NONCE_W`).
  - The issue carrying nonce 2^`NONCE_W`−1 is the last one. Go to DRAIN and start the drain counter at `LANE_LAT`.
- DRAIN:
  - `lane_issue`=0.
  - Decrement the drain counter each cycle. When it reaches 0, go to IDLE and pulse `job_done`.
- `work_abort` in RUN or DRAIN:
  - Go to IDLE on the next edge. `lane_issue` drops that edge.
  - No `job_done` pulse.
  - FIFO contents are retained.
  - `work_abort` in IDLE is ignored.
- Hit capture:
  - Capture only in RUN or DRAIN; hits in IDLE are ignored and not counted.
  - When several lanes hit in the same cycle, push the lowest-index lane's nonce. Every other hit that cycle adds 1 to `drop_count`.
  - A push into a full FIFO with no pop that cycle is dropped and adds 1 to `drop_count`.
  - A push and a pop in the same cycle on a full FIFO both succeed.
  - `drop_count` saturates at 0xFFFF.
- FIFO: show-ahead; pop occurs when `gold_valid` && `gold_ready`; order is preserved.
- Hashrate:
  - The window counter runs freely, 0 to `WINDOW`−1.
  - The accumulator adds `LANES` on each issue cycle.
  - In the cycle where the window counter equals `WINDOW`−1, `hashrate` <= accumulator plus that cycle's contribution, and the accumulator clears.
  - 32-bit saturating.
- `busy` is high in RUN and DRAIN.

## Timing
- Reset values:
  - Every output is 0 during reset, including `work_ready`, `lane_header`, `hashrate`, `drop_count` and `gold_valid`.
  - The FSM, FIFO pointers, window counter and accumulator clear.
  - The cycle after `rst` falls, the block is in IDLE with `work_ready`=1.
- Work accepted on edge T:
  - `lane_issue`=1 from T+1 with nonces {`LANES`−1 … 0}.
  - The last issue is at T+2^`NONCE_W`/`LANES`.
  - DRAIN lasts `LANE_LAT` cycles.
  - `job_done` and `work_ready` rise together one cycle after DRAIN ends.
- Outputs:
  - `lane_nonce`, `lane_issue`, `hashrate`, `drop_count` and `gold_nonce` are all registered.
  - `work_ready` and `gold_valid` are decoded from registers, so no combinational input-to-output paths exist.
- A hit sampled on edge E shows on `gold_valid` from E+1 if the FIFO was empty.
- `rst` asserted mid-job: the block returns immediately to the reset values and all in-flight hits are lost.

## Test plan
- Full sweep, `NONCE_W`=8, `LANES`=4, `LANE_LAT`=4; accept work on edge T:
  - T+1 `lane_nonce`={3,2,1,0}.
  - T+64 `lane_nonce`={255,254,253,252}.
  - `lane_issue` low from T+65.
  - `job_done` pulses at T+69 with `work_ready`=1.
- Collision: lanes 1 and 3 hit in the same cycle with nonces 0x21 and 0x23 → FIFO receives only 0x21; `drop_count`=1.
- Overflow, `FIFO_DEPTH`=4, `gold_ready`=0:
  - 5 single hits with nonces 0x10–0x14 → 4 entries held; `drop_count`=1.
  - Then `gold_ready`=1 → pops 0x10, 0x11, 0x12, 0x13 on consecutive cycles; `gold_valid` falls afterwards.
- Hashrate, `WINDOW`=16, `LANES`=4:
  - A window fully inside RUN → `hashrate`=64.
  - A following window fully in IDLE → `hashrate`=0.
- Abort on the 10th issue cycle:
  - `lane_issue`=0 and `work_ready`=1 the next cycle.
  - No `job_done` pulse.
  - A pre-abort FIFO entry stays readable; a hit injected after the abort is ignored and `drop_count` is unchanged.
- `rst` asserted mid-RUN with the FIFO non-empty → every output reads 0 asynchronously; after release, a new job starts again from nonce 0.

Source files
------------

// File: rtl/vault_mining_scheduler_if.sv
// Work, hash-lane and golden-nonce signals of the vault mining scheduler.
// master = scheduler side, slave = feeder / lane array / consumer side.
interface vault_mining_scheduler_if #(
  parameter int LANES   = 4,
  parameter int NONCE_W = 32,
  parameter int HDR_W   = 640
);
  logic                     work_valid;
  logic [HDR_W-1:0]         work_header;
  logic                     work_ready;
  logic                     work_abort;
  logic [HDR_W-1:0]         lane_header;
  logic                     lane_issue;
  logic [LANES*NONCE_W-1:0] lane_nonce;
  logic [LANES-1:0]         lane_hit;
  logic [LANES*NONCE_W-1:0] lane_hit_nonce;
  logic                     gold_valid;
  logic [NONCE_W-1:0]       gold_nonce;
  logic                     gold_ready;

  modport master (
    input  work_valid, work_header, work_abort, lane_hit, lane_hit_nonce, gold_ready,
    output work_ready, lane_header, lane_issue, lane_nonce, gold_valid, gold_nonce
  );

  modport slave (
    output work_valid, work_header, work_abort, lane_hit, lane_hit_nonce, gold_ready,
    input  work_ready, lane_header, lane_issue, lane_nonce, gold_valid, gold_nonce
  );
endinterface

// File: rtl/vault_mining_scheduler.sv
// Sweeps the nonce space across LANES hash lanes, collects golden-nonce hits
// into a show-ahead FIFO and measures issued hashes per fixed cycle window.
module vault_mining_scheduler #(
  parameter int LANES      = 4,
  parameter int NONCE_W    = 32,
  parameter int HDR_W      = 640,
  parameter int LANE_LAT   = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int WINDOW     = 100000000
) (
  input  logic                     clk,
  input  logic                     rst,
  vault_mining_scheduler_if.master bus,
  output logic [31:0]              hashrate,
  output logic [15:0]              drop_count,
  output logic                     busy,
  output logic                     job_done
);
  localparam int DW = $clog2(LANE_LAT + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(WINDOW);
  localparam int LW = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state, state_nx;
  logic                     alive;
  logic                     issue_q, issue_nx;
  logic [NONCE_W-1:0]       base, base_nx;
  logic [LANES*NONCE_W-1:0] nonce_q, nonce_nx;
  logic [DW-1:0]            drain_cnt, drain_nx;
  logic                     done_nx;
  logic [HDR_W-1:0]         hdr_q;
  logic                     accept;

  // alive keeps work_ready low while reset is held even though state is IDLE
  assign accept = (state == IDLE) && alive && bus.work_valid;

  // base holds the first nonce of the next issue; it wraps to 0 once the
  // issue carrying the all-ones nonce has been loaded
  always_comb begin
    state_nx = state;
    issue_nx = issue_q;
    base_nx  = base;
    nonce_nx = nonce_q;
    drain_nx = drain_cnt;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = RUN;
          issue_nx = 1'b1;
          base_nx  = NONCE_W'(LANES);
          for (int i = 0; i < LANES; i++) nonce_nx[i*NONCE_W +: NONCE_W] = NONCE_W'(i);
        end
      end
      RUN: begin
        if (bus.work_abort) begin
          state_nx = IDLE;
          issue_nx = 1'b0;
        end else if (base == '0) begin
          state_nx = DRAIN;
          issue_nx = 1'b0;
          drain_nx = DW'(LANE_LAT);
        end else begin
          for (int i = 0; i < LANES; i++) nonce_nx[i*NONCE_W +: NONCE_W] = base + NONCE_W'(i);
          base_nx = base + NONCE_W'(LANES);
        end
      end
      DRAIN: begin
        if (bus.work_abort) begin
          state_nx = IDLE;
        end else if (drain_cnt == DW'(1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          drain_nx = drain_cnt - DW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alive     <= 1'b0;
      issue_q   <= 1'b0;
      base      <= '0;
      nonce_q   <= '0;
      drain_cnt <= '0;
      job_done  <= 1'b0;
      hdr_q     <= '0;
    end else begin
      state     <= state_nx;
      alive     <= 1'b1;
      issue_q   <= issue_nx;
      base      <= base_nx;
      nonce_q   <= nonce_nx;
      drain_cnt <= drain_nx;
      job_done  <= done_nx;
      if (accept) hdr_q <= bus.work_header;
    end
  end

  logic               capture, hit_any;
  logic [NONCE_W-1:0] hit_sel;
  logic [LW-1:0]      hit_cnt;

  assign capture = (state == RUN) || (state == DRAIN);

  // descending scan leaves the lowest-index hitting lane selected
  always_comb begin
    hit_any = 1'b0;
    hit_sel = '0;
    hit_cnt = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (bus.lane_hit[i]) begin
        hit_any = 1'b1;
        hit_sel = bus.lane_hit_nonce[i*NONCE_W +: NONCE_W];
      end
    end
    for (int i = 0; i < LANES; i++) hit_cnt = hit_cnt + LW'(bus.lane_hit[i]);
  end

  logic [NONCE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push, pop, push_ok;
  logic [16:0]        drop_sum;

  assign pop     = (count != '0) && bus.gold_ready;
  assign push    = capture && hit_any;
  assign push_ok = push && ((count != CW'(FIFO_DEPTH)) || pop);

  always_comb begin
    drop_sum = {1'b0, drop_count};
    if (push)            drop_sum = drop_sum + 17'(hit_cnt) - 17'd1;
    if (push && !push_ok) drop_sum = drop_sum + 17'd1;
  end

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= hit_sel;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count      <= count + CW'(push_ok) - CW'(pop);
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  logic [WW-1:0] wcnt;
  logic [31:0]   acc, acc_sat;
  logic [32:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + (issue_q ? 33'(LANES) : 33'd0);
  assign acc_sat = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt     <= '0;
      acc      <= '0;
      hashrate <= '0;
    end else if (wcnt == WW'(WINDOW - 1)) begin
      wcnt     <= '0;
      acc      <= '0;
      hashrate <= acc_sat;
    end else begin
      wcnt <= wcnt + WW'(1);
      acc  <= acc_sat;
    end
  end

  assign bus.work_ready  = (state == IDLE) && alive;
  assign bus.lane_header = hdr_q;
  assign bus.lane_issue  = issue_q;
  assign bus.lane_nonce  = nonce_q;
  assign bus.gold_valid  = (count != '0);
  assign bus.gold_nonce  = mem[rd_ptr];
  assign busy            = (state != IDLE);
endmodule

// File: tb/tb_vault_mining_scheduler.sv
// Directed bench for vault_mining_scheduler: hit-capture vector table plus
// hand-written sequences for sweep, overflow, hashrate, abort and reset.
module tb_vault_mining_scheduler;
  localparam int LANES      = 4;
  localparam int NONCE_W    = 8;
  localparam int HDR_W      = 16;
  localparam int LANE_LAT   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int WINDOW     = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hashrate;
  logic [15:0] drop_count;
  logic        busy;
  logic        job_done;
  int          checks = 0;
  int          errors = 0;

  vault_mining_scheduler_if #(.LANES(LANES), .NONCE_W(NONCE_W), .HDR_W(HDR_W)) bus ();

  vault_mining_scheduler #(
    .LANES(LANES), .NONCE_W(NONCE_W), .HDR_W(HDR_W),
    .LANE_LAT(LANE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .WINDOW(WINDOW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hashrate(hashrate), .drop_count(drop_count), .busy(busy), .job_done(job_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  hit;
    logic [31:0] nonces;
    logic [7:0]  exp_head;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_work_ready"}, 64'(bus.work_ready), 0);
    check({tag, "_lane_header"}, 64'(bus.lane_header), 0);
    check({tag, "_lane_issue"}, 64'(bus.lane_issue), 0);
    check({tag, "_lane_nonce"}, 64'(bus.lane_nonce), 0);
    check({tag, "_gold_valid"}, 64'(bus.gold_valid), 0);
    check({tag, "_gold_nonce"}, 64'(bus.gold_nonce), 0);
    check({tag, "_hashrate"}, 64'(hashrate), 0);
    check({tag, "_drop_count"}, 64'(drop_count), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_job_done"}, 64'(job_done), 0);
  endtask

  task automatic start_job(input logic [15:0] hdr);
    bus.work_header = hdr;
    bus.work_valid  = 1'b1;
    step();
    bus.work_valid  = 1'b0;
    bus.work_header = '0;
  endtask

  task automatic hit_once(input logic [3:0] mask, input logic [31:0] nonces);
    bus.lane_hit       = mask;
    bus.lane_hit_nonce = nonces;
    step();
    bus.lane_hit       = '0;
    bus.lane_hit_nonce = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!job_done && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (!job_done) begin
      errors++;
      $display("FAIL %s: job_done got 0 expected 1 within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_nonce;

    vecs[0] = '{4'b0001, 32'h0000_0005, 8'h05, 16'd0};
    vecs[1] = '{4'b1010, 32'h2300_2100, 8'h21, 16'd1};
    vecs[2] = '{4'b1111, 32'h3332_3130, 8'h30, 16'd4};
    vecs[3] = '{4'b1000, 32'h4400_0000, 8'h44, 16'd4};
    vecs[4] = '{4'b0110, 32'h0052_5100, 8'h51, 16'd5};
    vecs[5] = '{4'b0100, 32'h0062_0000, 8'h62, 16'd5};

    rst                = 1'b1;
    bus.work_valid     = 1'b0;
    bus.work_header    = '0;
    bus.work_abort     = 1'b0;
    bus.lane_hit       = '0;
    bus.lane_hit_nonce = '0;
    bus.gold_ready     = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check("ready_after_reset", 64'(bus.work_ready), 1);

    // full sweep of the 8-bit nonce space
    start_job(16'hBEEF);
    check("sweep_ready_low", 64'(bus.work_ready), 0);
    check("sweep_busy", 64'(busy), 1);
    check("sweep_header", 64'(bus.lane_header), 64'h BEEF);
    for (int k = 0; k < 64; k++) begin
      for (int j = 0; j < 4; j++) exp_nonce[j*8 +: 8] = 8'(k * 4 + j);
      check("sweep_issue", 64'(bus.lane_issue), 1);
      check("sweep_nonce", 64'(bus.lane_nonce), 64'(exp_nonce));
      if (k == 47) check("hashrate_run", 64'(hashrate), 64);
      if (k < 63) step();
    end
    step();
    check("drain_issue_low", 64'(bus.lane_issue), 0);
    check("drain_busy", 64'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      check("drain_no_done", 64'(job_done), 0);
      step();
    end
    check("sweep_job_done", 64'(job_done), 1);
    check("sweep_ready_back", 64'(bus.work_ready), 1);
    check("sweep_idle_busy", 64'(busy), 0);
    step();
    check("job_done_one_cycle", 64'(job_done), 0);

    hit_once(4'b0001, 32'h77);
    check("idle_hit_ignored", 64'(bus.gold_valid), 0);
    check("idle_hit_no_drop", 64'(drop_count), 0);
    for (int k = 0; k < 40; k++) step();
    check("hashrate_idle", 64'(hashrate), 0);

    // hit-capture vector table, then overflow and push+pop on full
    start_job(16'h1234);
    for (int v = 0; v < 6; v++) begin
      hit_once(vecs[v].hit, vecs[v].nonces);
      check("vec_valid", 64'(bus.gold_valid), 1);
      check("vec_head", 64'(bus.gold_nonce), 64'(vecs[v].exp_head));
      check("vec_drop", 64'(drop_count), 64'(vecs[v].exp_drop));
      bus.gold_ready = 1'b1;
      step();
      bus.gold_ready = 1'b0;
      check("vec_popped", 64'(bus.gold_valid), 0);
    end

    for (int i = 0; i < 5; i++) hit_once(4'b0001, 32'(8'h10 + i));
    check("ovf_valid", 64'(bus.gold_valid), 1);
    check("ovf_head", 64'(bus.gold_nonce), 64'h10);
    check("ovf_drop", 64'(drop_count), 6);
    bus.gold_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_pop_valid", 64'(bus.gold_valid), 1);
      check("ovf_pop_head", 64'(bus.gold_nonce), 64'(8'h10 + i));
      step();
    end
    bus.gold_ready = 1'b0;
    check("ovf_empty", 64'(bus.gold_valid), 0);

    for (int i = 0; i < 4; i++) hit_once(4'b0001, 32'(8'h70 + i));
    bus.gold_ready = 1'b1;
    hit_once(4'b0001, 32'h74);
    bus.gold_ready = 1'b0;
    check("full_pushpop_drop", 64'(drop_count), 6);
    check("full_pushpop_head", 64'(bus.gold_nonce), 64'h71);
    bus.gold_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_pushpop_order", 64'(bus.gold_nonce), 64'(8'h71 + i));
      step();
    end
    bus.gold_ready = 1'b0;
    check("full_pushpop_empty", 64'(bus.gold_valid), 0);
    wait_done("job2_done", 100);
    step();

    // abort on the 10th issue cycle
    start_job(16'h5555);
    hit_once(4'b0100, 32'h0099_0000);
    for (int k = 0; k < 8; k++) step();
    check("abort_10th_nonce", 64'(bus.lane_nonce[7:0]), 36);
    check("abort_10th_issue", 64'(bus.lane_issue), 1);
    bus.work_abort = 1'b1;
    step();
    bus.work_abort = 1'b0;
    check("abort_issue_low", 64'(bus.lane_issue), 0);
    check("abort_ready", 64'(bus.work_ready), 1);
    check("abort_busy", 64'(busy), 0);
    check("abort_no_done", 64'(job_done), 0);
    check("abort_fifo_kept", 64'(bus.gold_nonce), 64'h99);
    hit_once(4'b0001, 32'hAA);
    check("abort_hit_head", 64'(bus.gold_nonce), 64'h99);
    check("abort_hit_drop", 64'(drop_count), 6);
    for (int k = 0; k < 8; k++) begin
      check("abort_no_done_later", 64'(job_done), 0);
      step();
    end
    bus.gold_ready = 1'b1;
    step();
    bus.gold_ready = 1'b0;
    check("abort_hit_not_pushed", 64'(bus.gold_valid), 0);

    // reset asserted mid-run with a non-empty FIFO
    start_job(16'hA5A5);
    hit_once(4'b1000, 32'h5A00_0000);
    for (int k = 0; k < 3; k++) step();
    check("pre_reset_valid", 64'(bus.gold_valid), 1);
    check("pre_reset_issue", 64'(bus.lane_issue), 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    step();
    rst = 1'b0;
    step();
    check("post_reset_ready", 64'(bus.work_ready), 1);
    start_job(16'h0F0F);
    check("post_reset_issue", 64'(bus.lane_issue), 1);
    check("post_reset_nonce", 64'(bus.lane_nonce), 64'h0302_0100);
    check("post_reset_fifo", 64'(bus.gold_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
